// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the operand-forwarding / hazard unit.
//   - forward-select encoding constants used on ex_fwd_sel
//   - fwd_slot_t: one tag-pipeline slot {valid, rd, is_load}
//   - fwd_clog2: elaboration-time ceil(log2) helper
package fwd_pkg;

  // Forward-select encoding: 0 = register file, k = stage-k result.
  localparam int FWD_RF    = 0;
  localparam int FWD_EXMEM = 1;
  localparam int FWD_MEMWB = 2;

  // Slot rd storage width. Register indices narrower than this are
  // zero-extended on entry so every stored bit takes part in the compare.
  localparam int FWD_RD_W = 16;

  typedef struct packed {
    logic                valid;
    logic [FWD_RD_W-1:0] rd;
    logic                is_load;
  } fwd_slot_t;

  function automatic int fwd_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// fwd_tag_pipe: shift register of destination tags for in-flight
// instructions. Slot 0 is EX, slot NSTAGE is the last forwarding stage;
// every cycle slot k moves to k+1 and slot NSTAGE retires.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears valids)
//   ins_valid     a real instruction enters slot 0 this cycle (else bubble)
//   ins_regwrite  entering instruction writes ins_rd
//   ins_is_load   entering instruction is a load
//   ins_rd        entering destination register
//   slots         per-slot {valid, rd, is_load}, index 0..NSTAGE
module fwd_tag_pipe
  import fwd_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int NSTAGE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  input  logic             ins_regwrite,
  input  logic             ins_is_load,
  input  logic [REG_W-1:0] ins_rd,
  output fwd_slot_t        slots [NSTAGE+1]
);

  logic [NSTAGE:0]     slot_vld_p;
  logic [NSTAGE:0]     slot_load_p;
  logic [FWD_RD_W-1:0] slot_rd_p [NSTAGE+1];
  logic                writer;

  // Only real register writers are tracked; r0 and non-writing
  // instructions are stored as invalid so they can never match.
  assign writer = ins_valid & ins_regwrite & (ins_rd != '0);

  // ---- slot valid bits (control, reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_p <= '0;
    end else begin
      slot_vld_p <= {slot_vld_p[NSTAGE-1:0], writer};
    end
  end

  // ---- slot payload (data, not reset) ----
  always_ff @(posedge clk) begin
    slot_rd_p[0]   <= FWD_RD_W'(ins_rd);
    slot_load_p[0] <= ins_is_load;
    for (int k = 1; k <= NSTAGE; k++) begin
      slot_rd_p[k]   <= slot_rd_p[k-1];
      slot_load_p[k] <= slot_load_p[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k <= NSTAGE; k++) begin
      slots[k].valid   = slot_vld_p[k];
      slots[k].rd      = slot_rd_p[k];
      slots[k].is_load = slot_load_p[k];
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select generation and load-use
// stall detection for the instruction in ID.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   id_valid      ID holds a real instruction
//   id_regwrite   ID instruction writes id_rd
//   id_is_load    ID instruction is a load
//   id_rd         ID destination register
//   id_src        ID source registers, operand 0 in the LSBs
//   id_src_used   per-operand "operand is read"
//   flush         kill the ID instruction
//   stall         combinational: hold PC/IF/ID, bubble into EX
//   ex_fwd_sel    registered per-operand select (0 = regfile, k = stage k)
//   stall_cnt     saturating count of stall cycles
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int  REG_W    = 5,
  parameter int  NSRC     = 2,
  parameter int  NSTAGE   = 3,
  parameter int  LOAD_LAT = 2,
  parameter int  CNT_W    = 16,
  localparam int SEL_W    = fwd_clog2(NSTAGE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_regwrite,
  input  logic                  id_is_load,
  input  logic [REG_W-1:0]      id_rd,
  input  logic [NSRC*REG_W-1:0] id_src,
  input  logic [NSRC-1:0]       id_src_used,
  input  logic                  flush,
  output logic                  stall,
  output logic [NSRC*SEL_W-1:0] ex_fwd_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  fwd_slot_t           slots [NSTAGE+1];
  logic                issue;
  logic [FWD_RD_W-1:0] src_ext  [NSRC];
  logic [SEL_W-1:0]    op_stage [NSRC];
  logic [NSRC-1:0]     op_hit;
  logic [NSRC-1:0]     op_wait;
  logic [NSRC*SEL_W-1:0] sel_nxt;

  // Slot 0 receives the ID instruction only when it actually advances.
  assign issue = id_valid & ~stall & ~flush;

  fwd_tag_pipe #(
    .REG_W  (REG_W),
    .NSTAGE (NSTAGE)
  ) u_tag_pipe (
    .clk          (clk),
    .rst          (rst),
    .ins_valid    (issue),
    .ins_regwrite (id_regwrite),
    .ins_is_load  (id_is_load),
    .ins_rd       (id_rd),
    .slots        (slots)
  );

  // Priority search. Slots are scanned oldest to youngest so the last hit
  // (the youngest producer) overrides; readiness is judged only on that
  // winner, an older ready copy never rescues a waiting load. Slot NSTAGE
  // is not searched: it retires into the regfile this cycle.
  always_comb begin
    op_hit  = '0;
    op_wait = '0;
    sel_nxt = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_ext[i]  = FWD_RD_W'(id_src[i*REG_W +: REG_W]);
      op_stage[i] = SEL_W'(FWD_RF);
      if (id_src_used[i] && (src_ext[i] != '0)) begin
        for (int k = NSTAGE - 1; k >= 0; k--) begin
          if (slots[k].valid && (slots[k].rd == src_ext[i])) begin
            op_hit[i]   = 1'b1;
            op_stage[i] = SEL_W'(k + 1);
            op_wait[i]  = slots[k].is_load && ((k + 1) < LOAD_LAT);
          end
        end
      end
      if (op_hit[i] && !op_wait[i]) begin
        sel_nxt[i*SEL_W +: SEL_W] = op_stage[i];
      end
    end
  end

  // Held low while reset is asserted so stale tags cannot stall the front end.
  assign stall = ~rst & id_valid & ~flush & (|op_wait);

  // ---- ID -> EX select register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_fwd_sel <= '0;
    end else if (issue) begin
      ex_fwd_sel <= sel_nxt;
    end else begin
      ex_fwd_sel <= '0;
    end
  end

  // ---- stall counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
